// File: rtl/rv_alu_ex.sv
// Execute-stage ALU for the RV64 core with a valid/ready handshake and registered result.
// Define RV_ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; otherwise shifts iterate one bit per cycle.
`timescale 1ns/1ps
module rv_alu_ex #(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [3:0]      alu_op_sel_i,
   input  logic            alu_op_32b_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            zero_o,
   output logic            illegal_o
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

`ifdef RV_ALU_FAST_SHIFT_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
`endif

   // Word ops sign-extend bit 31 of whatever the operation produced.
   function automatic logic [XLEN-1:0] fin_word(input logic w32, input logic [XLEN-1:0] v);
      return w32 ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   state_t            w_acc_state;
   logic [XLEN-1:0]   r_result;
   logic              r_zero;
   logic              r_illegal;
   logic              w_accept;
   logic              w_legal;
   logic              w_slt;
   logic              w_sltu;
   logic [5:0]        w_shamt;
   logic [XLEN-1:0]   w_work;
   logic [XLEN-1:0]   w_raw;
   logic [XLEN-1:0]   w_res;

   assign in_ready_o = !flush_i && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready_i));
   assign w_accept   = in_valid_i && in_ready_o;

   assign w_slt  = alu_op_32b_i ? ($signed(op_a_i[31:0]) < $signed(op_b_i[31:0]))
                                : ($signed(op_a_i) < $signed(op_b_i));
   assign w_sltu = alu_op_32b_i ? (op_a_i[31:0] < op_b_i[31:0]) : (op_a_i < op_b_i);

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_legal = 1'b1;
      w_raw   = '0;
      w_shamt = alu_op_32b_i ? {1'b0, op_b_i[4:0]} : op_b_i[5:0];
      w_work  = op_a_i;
      if (alu_op_32b_i && (alu_op_sel_i == OP_SRL))
         w_work = {{(XLEN-32){1'b0}}, op_a_i[31:0]};
      if (alu_op_32b_i && (alu_op_sel_i == OP_SRA))
         w_work = {{(XLEN-32){op_a_i[31]}}, op_a_i[31:0]};
      case (alu_op_sel_i)
         OP_ADD:  w_raw = op_a_i + op_b_i;
         OP_SUB:  w_raw = op_a_i - op_b_i;
         OP_SLT:  w_raw = {{(XLEN-1){1'b0}}, w_slt};
         OP_SLTU: w_raw = {{(XLEN-1){1'b0}}, w_sltu};
         OP_XOR:  w_raw = op_a_i ^ op_b_i;
         OP_OR:   w_raw = op_a_i | op_b_i;
         OP_AND:  w_raw = op_a_i & op_b_i;
`ifdef RV_ALU_FAST_SHIFT_EN
         OP_SLL:  w_raw = w_work << w_shamt;
         OP_SRL:  w_raw = w_work >> w_shamt;
         OP_SRA:  w_raw = XLEN'($signed(w_work) >>> w_shamt);
`else
         // Only shift-by-0 completes here; longer shifts go through the SHIFT state.
         OP_SLL, OP_SRL, OP_SRA: w_raw = w_work;
`endif
         default: w_legal = 1'b0;
      endcase
      w_res = w_legal ? fin_word(alu_op_32b_i, w_raw) : '0;
   end

`ifdef RV_ALU_FAST_SHIFT_EN
   assign w_acc_state = ST_DONE;
`else
   logic [XLEN-1:0]   r_work;
   logic [5:0]        r_cnt;
   logic [3:0]        r_kind;
   logic              r_w32;
   logic              w_to_shift;
   logic [XLEN-1:0]   w_step;
   logic [XLEN-1:0]   w_step_fin;

   assign w_to_shift  = ((alu_op_sel_i == OP_SLL) || (alu_op_sel_i == OP_SRL) ||
                         (alu_op_sel_i == OP_SRA)) && (w_shamt != 6'd0);
   assign w_acc_state = w_to_shift ? ST_SHIFT : ST_DONE;

   always_comb begin
      case (r_kind)
         OP_SLL:  w_step = r_work << 1;
         OP_SRL:  w_step = r_work >> 1;
         default: w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
      endcase
      w_step_fin = fin_word(r_w32, w_step);
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = w_acc_state;
`ifndef RV_ALU_FAST_SHIFT_EN
         ST_SHIFT: if (r_cnt == 6'd1) w_state_nxt = ST_DONE;
`endif
         ST_DONE: begin
            if (w_accept)
               w_state_nxt = w_acc_state;
            else if (out_ready_i)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (flush_i)
         w_state_nxt = ST_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_illegal <= 1'b0;
`ifndef RV_ALU_FAST_SHIFT_EN
         r_work    <= '0;
         r_cnt     <= '0;
         r_kind    <= OP_SLL;
         r_w32     <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
`ifdef RV_ALU_FAST_SHIFT_EN
         if (w_accept) begin
            r_result  <= w_res;
            r_zero    <= (w_res == '0);
            r_illegal <= !w_legal;
         end
`else
         if (w_accept) begin
            if (w_to_shift) begin
               r_work <= w_work;
               r_cnt  <= w_shamt;
               r_kind <= alu_op_sel_i;
               r_w32  <= alu_op_32b_i;
            end else begin
               r_result  <= w_res;
               r_zero    <= (w_res == '0);
               r_illegal <= !w_legal;
            end
         end else if ((r_state == ST_SHIFT) && !flush_i) begin
            r_work <= w_step;
            r_cnt  <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
               r_result  <= w_step_fin;
               r_zero    <= (w_step_fin == '0);
               r_illegal <= 1'b0;
            end
         end
`endif
      end
   end

   assign out_valid_o = (r_state == ST_DONE);
   assign result_o    = r_result;
   assign zero_o      = r_zero;
   assign illegal_o   = r_illegal;

endmodule
